// File: rtl/soc_addr_decode_errslv.sv
// rtl/soc_addr_decode_errslv.sv - AXI request address decoder with DECERR default slave
//
// Decodes AR/AW requests against the SoC address map (10 regions) and forwards hits
// with a slave index (DRAM=0 .. Debug=9). Misses go to an internal default slave.
// For a missed write it drains W beats and then returns B DECERR. For a missed read
// it returns len+1 R beats with DECERR. It also keeps a saturating count of misses.
//
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   req_valid_i/req_ready_o       request handshake
//   req_addr_i/id/len/write       request fields
//   fwd_valid_o/fwd_ready_i       forwarded hit handshake
//   fwd_addr/id/len/write/idx_o   registered hit fields and target slave index
//   w_valid_i/w_last_i/w_ready_o  W drain for errored writes
//   b_valid_o/b_ready_i/b_id_o/b_resp_o              error write response
//   r_valid_o/r_ready_i/r_id_o/r_data_o/r_resp_o/r_last_o  error read response
//   decerr_cnt_o                  saturating miss counter
module soc_addr_decode_errslv #(
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned IdWidth   = 6,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned NumRules  = 10
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic [IdWidth-1:0]   req_id_i,
  input  logic [7:0]           req_len_i,
  input  logic                 req_write_i,
  output logic                 fwd_valid_o,
  input  logic                 fwd_ready_i,
  output logic [AddrWidth-1:0] fwd_addr_o,
  output logic [IdWidth-1:0]   fwd_id_o,
  output logic [7:0]           fwd_len_o,
  output logic                 fwd_write_o,
  output logic [3:0]           fwd_idx_o,
  input  logic                 w_valid_i,
  input  logic                 w_last_i,
  output logic                 w_ready_o,
  output logic                 b_valid_o,
  input  logic                 b_ready_i,
  output logic [IdWidth-1:0]   b_id_o,
  output logic [1:0]           b_resp_o,
  output logic                 r_valid_o,
  input  logic                 r_ready_i,
  output logic [IdWidth-1:0]   r_id_o,
  output logic [DataWidth-1:0] r_data_o,
  output logic [1:0]           r_resp_o,
  output logic                 r_last_o,
  output logic [31:0]          decerr_cnt_o
);

  // Index i of each array is the slave index; the leftmost entry is index 9 (Debug).
  localparam logic [NumRules-1:0][AddrWidth-1:0] RuleBase = {
    64'h0000_0000_0000_0000,  // 9 Debug
    64'h0000_0000_0001_0000,  // 8 ROM
    64'h0000_0000_0200_0000,  // 7 CLINT
    64'h0000_0000_0C00_0000,  // 6 PLIC
    64'h0000_0000_1000_0000,  // 5 UART
    64'h0000_0000_1800_0000,  // 4 Timer
    64'h0000_0000_2000_0000,  // 3 SPI
    64'h0000_0000_3000_0000,  // 2 Ethernet
    64'h0000_0000_4000_0000,  // 1 GPIO
    64'h0000_0000_8000_0000   // 0 DRAM
  };
  localparam logic [NumRules-1:0][AddrWidth-1:0] RuleLen = {
    64'h0000_0000_0000_1000,
    64'h0000_0000_0001_0000,
    64'h0000_0000_000C_0000,
    64'h0000_0000_03FF_FFFF,
    64'h0000_0000_0000_1000,
    64'h0000_0000_0000_1000,
    64'h0000_0000_0080_0000,
    64'h0000_0000_0001_0000,
    64'h0000_0000_0000_1000,
    64'h0000_0000_4000_0000
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ERR_W = 2'd1,
    ERR_B = 2'd2,
    ERR_R = 2'd3
  } state_t;

  state_t             state;
  logic               dec_hit;
  logic [3:0]         dec_idx;
  logic               accept;
  logic [8:0]         beat_cnt;
  logic [IdWidth-1:0] err_id;

  // Regions are disjoint, so at most one rule matches.
  always_comb begin
    dec_hit = 1'b0;
    dec_idx = 4'd0;
    for (int i = 0; i < NumRules; i++) begin
      if ((req_addr_i >= RuleBase[i]) && (req_addr_i < RuleBase[i] + RuleLen[i])) begin
        dec_hit = 1'b1;
        dec_idx = 4'(i);
      end
    end
  end

  // A new request is taken only when the fwd register is empty or draining this cycle.
  assign req_ready_o = (state == IDLE) && (!fwd_valid_o || fwd_ready_i);
  assign accept      = req_valid_i && req_ready_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fwd_valid_o <= 1'b0;
      fwd_addr_o  <= '0;
      fwd_id_o    <= '0;
      fwd_len_o   <= '0;
      fwd_write_o <= 1'b0;
      fwd_idx_o   <= '0;
    end else if (accept && dec_hit) begin
      fwd_valid_o <= 1'b1;
      fwd_addr_o  <= req_addr_i;
      fwd_id_o    <= req_id_i;
      fwd_len_o   <= req_len_i;
      fwd_write_o <= req_write_i;
      fwd_idx_o   <= dec_idx;
    end else if (fwd_ready_i) begin
      fwd_valid_o <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= IDLE;
      w_ready_o    <= 1'b0;
      b_valid_o    <= 1'b0;
      r_valid_o    <= 1'b0;
      r_last_o     <= 1'b0;
      beat_cnt     <= '0;
      err_id       <= '0;
      decerr_cnt_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept && !dec_hit) begin
            if (decerr_cnt_o != 32'hFFFF_FFFF) begin
              decerr_cnt_o <= decerr_cnt_o + 32'd1;
            end
            err_id   <= req_id_i;
            beat_cnt <= {1'b0, req_len_i};
            if (req_write_i) begin
              state     <= ERR_W;
              w_ready_o <= 1'b1;
            end else begin
              state     <= ERR_R;
              r_valid_o <= 1'b1;
              r_last_o  <= (req_len_i == 8'd0);
            end
          end
        end
        ERR_W: begin
          // The latched len is not checked; wlast alone ends the burst.
          if (w_valid_i && w_last_i) begin
            state     <= ERR_B;
            w_ready_o <= 1'b0;
            b_valid_o <= 1'b1;
          end
        end
        ERR_B: begin
          if (b_ready_i) begin
            state     <= IDLE;
            b_valid_o <= 1'b0;
          end
        end
        ERR_R: begin
          if (r_ready_i) begin
            if (r_last_o) begin
              state     <= IDLE;
              r_valid_o <= 1'b0;
              r_last_o  <= 1'b0;
            end else begin
              beat_cnt <= beat_cnt - 9'd1;
              r_last_o <= (beat_cnt == 9'd1);
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign b_id_o   = err_id;
  assign b_resp_o = 2'b11;
  assign r_id_o   = err_id;
  assign r_data_o = '0;
  assign r_resp_o = 2'b11;

endmodule

// File: tb/tb_soc_addr_decode_errslv.sv
// tb/tb_soc_addr_decode_errslv.sv - directed self-checking bench for soc_addr_decode_errslv
module tb_soc_addr_decode_errslv;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [63:0] req_addr_i;
  logic [5:0]  req_id_i;
  logic [7:0]  req_len_i;
  logic        req_write_i;
  logic        fwd_valid_o;
  logic        fwd_ready_i;
  logic [63:0] fwd_addr_o;
  logic [5:0]  fwd_id_o;
  logic [7:0]  fwd_len_o;
  logic        fwd_write_o;
  logic [3:0]  fwd_idx_o;
  logic        w_valid_i;
  logic        w_last_i;
  logic        w_ready_o;
  logic        b_valid_o;
  logic        b_ready_i;
  logic [5:0]  b_id_o;
  logic [1:0]  b_resp_o;
  logic        r_valid_o;
  logic        r_ready_i;
  logic [5:0]  r_id_o;
  logic [63:0] r_data_o;
  logic [1:0]  r_resp_o;
  logic        r_last_o;
  logic [31:0] decerr_cnt_o;

  int tests_run    = 0;
  int tests_failed = 0;

  soc_addr_decode_errslv dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_addr_i  (req_addr_i),
    .req_id_i    (req_id_i),
    .req_len_i   (req_len_i),
    .req_write_i (req_write_i),
    .fwd_valid_o (fwd_valid_o),
    .fwd_ready_i (fwd_ready_i),
    .fwd_addr_o  (fwd_addr_o),
    .fwd_id_o    (fwd_id_o),
    .fwd_len_o   (fwd_len_o),
    .fwd_write_o (fwd_write_o),
    .fwd_idx_o   (fwd_idx_o),
    .w_valid_i   (w_valid_i),
    .w_last_i    (w_last_i),
    .w_ready_o   (w_ready_o),
    .b_valid_o   (b_valid_o),
    .b_ready_i   (b_ready_i),
    .b_id_o      (b_id_o),
    .b_resp_o    (b_resp_o),
    .r_valid_o   (r_valid_o),
    .r_ready_i   (r_ready_i),
    .r_id_o      (r_id_o),
    .r_data_o    (r_data_o),
    .r_resp_o    (r_resp_o),
    .r_last_o    (r_last_o),
    .decerr_cnt_o(decerr_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Presents a request, waits (bounded) for req_ready_o, and returns #1 after the accepting edge.
  task automatic issue(input logic [63:0] addr, input logic [5:0] id, input logic [7:0] len,
                       input logic wr);
    int n;
    req_valid_i = 1'b1;
    req_addr_i  = addr;
    req_id_i    = id;
    req_len_i   = len;
    req_write_i = wr;
    #1;
    n = 0;
    while (!req_ready_o && n < 20) begin
      step();
      n++;
    end
    check("issue_ready", 64'(req_ready_o), 64'd1);
    step();
    req_valid_i = 1'b0;
  endtask

  // Drains an error read of the given length with r_ready held high.
  task automatic drain_r(input int beats);
    r_ready_i = 1'b1;
    for (int i = 0; i < beats; i++) step();
    r_ready_i = 1'b0;
    check("drain_r_idle", 64'(r_valid_o), 64'd0);
  endtask

  logic [63:0] b2b_addr [8];
  logic [3:0]  b2b_idx  [8];
  int          beats;
  int          cyc;
  logic        last_seen_early;

  initial begin
    b2b_addr[0] = 64'h1000_0010; b2b_idx[0] = 4'd5;
    b2b_addr[1] = 64'h4000_0FFC; b2b_idx[1] = 4'd1;
    b2b_addr[2] = 64'h0001_0000; b2b_idx[2] = 4'd8;
    b2b_addr[3] = 64'h020B_FFFF; b2b_idx[3] = 4'd7;
    b2b_addr[4] = 64'h0FFF_FFFE; b2b_idx[4] = 4'd6;
    b2b_addr[5] = 64'h1800_0000; b2b_idx[5] = 4'd4;
    b2b_addr[6] = 64'h207F_FFFF; b2b_idx[6] = 4'd3;
    b2b_addr[7] = 64'h3000_8000; b2b_idx[7] = 4'd2;

    rst_ni      = 1'b0;
    req_valid_i = 1'b0;
    req_addr_i  = '0;
    req_id_i    = '0;
    req_len_i   = '0;
    req_write_i = 1'b0;
    fwd_ready_i = 1'b0;
    w_valid_i   = 1'b0;
    w_last_i    = 1'b0;
    b_ready_i   = 1'b0;
    r_ready_i   = 1'b0;
    step();
    step();

    check("rst_fwd_valid", 64'(fwd_valid_o), 64'd0);
    check("rst_w_ready", 64'(w_ready_o), 64'd0);
    check("rst_b_valid", 64'(b_valid_o), 64'd0);
    check("rst_r_valid", 64'(r_valid_o), 64'd0);
    check("rst_r_last", 64'(r_last_o), 64'd0);
    check("rst_cnt", 64'(decerr_cnt_o), 64'd0);
    check("rst_fwd_addr", fwd_addr_o, 64'd0);
    check("rst_b_id", 64'(b_id_o), 64'd0);
    rst_ni = 1'b1;
    step();
    check("rst_req_ready", 64'(req_ready_o), 64'd1);

    // Test 1: DRAM hit held by backpressure
    issue(64'h8000_1000, 6'd1, 8'd3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("t1_fwd_valid", 64'(fwd_valid_o), 64'd1);
      check("t1_fwd_idx", 64'(fwd_idx_o), 64'd0);
      check("t1_fwd_addr", fwd_addr_o, 64'h8000_1000);
      check("t1_fwd_id", 64'(fwd_id_o), 64'd1);
      check("t1_fwd_len", 64'(fwd_len_o), 64'd3);
      check("t1_fwd_write", 64'(fwd_write_o), 64'd0);
      check("t1_req_ready_blocked", 64'(req_ready_o), 64'd0);
      step();
    end
    fwd_ready_i = 1'b1;
    #1;
    check("t1_req_ready_drain", 64'(req_ready_o), 64'd1);
    step();
    check("t1_fwd_drained", 64'(fwd_valid_o), 64'd0);

    // Test 2: region boundaries
    issue(64'hBFFF_FFFF, 6'd0, 8'd0, 1'b0);
    check("t2_top_dram_valid", 64'(fwd_valid_o), 64'd1);
    check("t2_top_dram_idx", 64'(fwd_idx_o), 64'd0);
    step();
    issue(64'hC000_0000, 6'd3, 8'd0, 1'b0);
    check("t2_miss_no_fwd", 64'(fwd_valid_o), 64'd0);
    check("t2_miss_cnt", 64'(decerr_cnt_o), 64'd1);
    check("t2_miss_r_valid", 64'(r_valid_o), 64'd1);
    check("t2_miss_r_last", 64'(r_last_o), 64'd1);
    drain_r(1);
    issue(64'h0000_0FFF, 6'd0, 8'd0, 1'b1);
    check("t2_debug_valid", 64'(fwd_valid_o), 64'd1);
    check("t2_debug_idx", 64'(fwd_idx_o), 64'd9);
    check("t2_debug_write", 64'(fwd_write_o), 64'd1);
    step();
    issue(64'h0000_1000, 6'd0, 8'd0, 1'b0);
    check("t2_miss2_no_fwd", 64'(fwd_valid_o), 64'd0);
    check("t2_miss2_cnt", 64'(decerr_cnt_o), 64'd2);
    drain_r(1);

    // Test 3: error read, 4 beats, r_ready toggling
    issue(64'h0000_2000, 6'd5, 8'd3, 1'b0);
    beats = 0;
    last_seen_early = 1'b0;
    cyc = 0;
    while (r_valid_o && cyc < 40) begin
      r_ready_i = cyc[0];
      #1;
      check("t3_req_ready_low", 64'(req_ready_o), 64'd0);
      if (r_ready_i) begin
        beats++;
        check("t3_r_id", 64'(r_id_o), 64'd5);
        check("t3_r_resp", 64'(r_resp_o), 64'd3);
        check("t3_r_data", r_data_o, 64'd0);
        check("t3_r_last", 64'(r_last_o), 64'(beats == 4));
      end
      step();
      cyc++;
    end
    r_ready_i = 1'b0;
    check("t3_beats", 64'(beats), 64'd4);
    check("t3_r_done", 64'(r_valid_o), 64'd0);
    check("t3_cnt", 64'(decerr_cnt_o), 64'd3);

    // Test 4: error write, 2 W beats, delayed B
    issue(64'h5000_0000, 6'd2, 8'd1, 1'b1);
    check("t4_no_fwd", 64'(fwd_valid_o), 64'd0);
    check("t4_w_ready1", 64'(w_ready_o), 64'd1);
    check("t4_b_early", 64'(b_valid_o), 64'd0);
    w_valid_i = 1'b1;
    w_last_i  = 1'b0;
    step();
    check("t4_w_ready2", 64'(w_ready_o), 64'd1);
    w_last_i = 1'b1;
    step();
    w_valid_i = 1'b0;
    w_last_i  = 1'b0;
    check("t4_w_ready_off", 64'(w_ready_o), 64'd0);
    for (int i = 0; i < 5; i++) begin
      check("t4_b_valid", 64'(b_valid_o), 64'd1);
      check("t4_b_id", 64'(b_id_o), 64'd2);
      check("t4_b_resp", 64'(b_resp_o), 64'd3);
      check("t4_req_ready_low", 64'(req_ready_o), 64'd0);
      step();
    end
    b_ready_i = 1'b1;
    step();
    b_ready_i = 1'b0;
    check("t4_b_done", 64'(b_valid_o), 64'd0);
    check("t4_cnt", 64'(decerr_cnt_o), 64'd4);

    // Test 5: 8 back-to-back hits
    fwd_ready_i = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) begin
        check("t5_fwd_valid", 64'(fwd_valid_o), 64'd1);
        check("t5_fwd_idx", 64'(fwd_idx_o), 64'(b2b_idx[k-1]));
        check("t5_fwd_addr", fwd_addr_o, b2b_addr[k-1]);
      end
      if (k < 8) begin
        req_valid_i = 1'b1;
        req_addr_i  = b2b_addr[k];
        req_id_i    = 6'(k);
        req_len_i   = 8'd0;
        req_write_i = 1'b0;
        #1;
        check("t5_req_ready", 64'(req_ready_o), 64'd1);
      end else begin
        req_valid_i = 1'b0;
      end
      step();
    end
    check("t5_fwd_empty", 64'(fwd_valid_o), 64'd0);

    // Test 6: reset in the middle of an error read
    issue(64'h0000_3000, 6'd7, 8'd3, 1'b0);
    check("t6_cnt_before", 64'(decerr_cnt_o), 64'd5);
    r_ready_i = 1'b1;
    step();
    check("t6_beat2_valid", 64'(r_valid_o), 64'd1);
    r_ready_i = 1'b0;
    #2;
    rst_ni = 1'b0;
    #1;
    check("t6_r_valid_rst", 64'(r_valid_o), 64'd0);
    check("t6_r_last_rst", 64'(r_last_o), 64'd0);
    check("t6_cnt_rst", 64'(decerr_cnt_o), 64'd0);
    check("t6_r_id_rst", 64'(r_id_o), 64'd0);
    step();
    rst_ni = 1'b1;
    step();
    check("t6_req_ready", 64'(req_ready_o), 64'd1);
    check("t6_r_valid_after", 64'(r_valid_o), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
